// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and helpers for the scan-chain load/unload blocks
package scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Width of a frame counter shared by both ends of the scan interface.
    localparam int FRAME_CNT_W = 16;

    // Beat counter width: enough to index WIDTH beats, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// rtl/scan_shreg.sv - WIDTH-bit parallel-load shift register with selectable shift direction
module scan_shreg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    logic [WIDTH-1:0] shifted;

    // Shift toward the output end; sin enters at the opposite end.
    generate
        if (WIDTH == 1) begin : g_single
            assign shifted = sin;
        end else if (LSB_FIRST) begin : g_lsb
            assign shifted = {sin, q[WIDTH-1:1]};
        end else begin : g_msb
            assign shifted = {q[WIDTH-2:0], sin};
        end
    endgenerate

    assign sout = LSB_FIRST ? q[0] : q[WIDTH-1];

    // Register update: a parallel load wins over a shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/scan_chain_unloader.sv
// rtl/scan_chain_unloader.sv - captures a parallel word and streams it out serially
module scan_chain_unloader
    import scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_valid,
    output logic                   cap_ready,
    input  logic [WIDTH-1:0]       cap_data,
    output logic                   so,
    output logic                   so_valid,
    output logic                   so_last,
    input  logic                   so_ready,
    output logic [FRAME_CNT_W-1:0] frames_sent
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             sout;
    logic             cap_fire;
    logic             beat;
    logic             shift;

    assign so_valid  = (state == SHIFT);
    assign so_last   = so_valid && (cnt == LAST_CNT);
    // After the final beat the register still holds that bit, so gate it off outside SHIFT.
    assign so        = so_valid && sout;
    assign cap_ready = !rst && ((state == IDLE) || (so_last && so_ready));
    assign cap_fire  = cap_valid && cap_ready;
    assign beat      = so_valid && so_ready;
    assign shift     = beat && !so_last;

    scan_shreg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (cap_fire),
        .shift (shift),
        .din   (cap_data),
        .sin   (1'b0),
        .q     (),
        .sout  (sout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave SHIFT after the last accepted beat unless a new word is ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cap_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (so_last && so_ready) begin
                    state_next = cap_valid ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter: restarts on capture, advances on each accepted non-final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cap_fire) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Frame counter: one count per fully transmitted word, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_sent <= '0;
        end else if (beat && so_last) begin
            frames_sent <= frames_sent + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_scan_chain_unloader.sv
// tb/tb_scan_chain_unloader.sv - directed self-checking bench for scan_chain_unloader
module tb_scan_chain_unloader;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Instance a: WIDTH=8, LSB first
    logic        a_cap_valid = 1'b0, a_cap_ready, a_so, a_so_valid, a_so_last, a_so_ready = 1'b0;
    logic [7:0]  a_cap_data  = 8'h00;
    logic [15:0] a_frames;
    // Instance b: WIDTH=8, MSB first
    logic        b_cap_valid = 1'b0, b_cap_ready, b_so, b_so_valid, b_so_last, b_so_ready = 1'b0;
    logic [7:0]  b_cap_data  = 8'h00;
    logic [15:0] b_frames;
    // Instance c: WIDTH=1
    logic        c_cap_valid = 1'b0, c_cap_ready, c_so, c_so_valid, c_so_last, c_so_ready = 1'b0;
    logic [0:0]  c_cap_data  = 1'b0;
    logic [15:0] c_frames;

    int tests  = 0;
    int failed = 0;

    scan_chain_unloader #(.WIDTH(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .cap_valid(a_cap_valid), .cap_ready(a_cap_ready),
        .cap_data(a_cap_data), .so(a_so), .so_valid(a_so_valid), .so_last(a_so_last),
        .so_ready(a_so_ready), .frames_sent(a_frames)
    );

    scan_chain_unloader #(.WIDTH(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .cap_valid(b_cap_valid), .cap_ready(b_cap_ready),
        .cap_data(b_cap_data), .so(b_so), .so_valid(b_so_valid), .so_last(b_so_last),
        .so_ready(b_so_ready), .frames_sent(b_frames)
    );

    scan_chain_unloader #(.WIDTH(1), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .cap_valid(c_cap_valid), .cap_ready(c_cap_ready),
        .cap_data(c_cap_data), .so(c_so), .so_valid(c_so_valid), .so_last(c_so_last),
        .so_ready(c_so_ready), .frames_sent(c_frames)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (a_cap_ready !== 1'b0) begin
                failed++;
                $display("FAIL reset_cap_ready cycle %0d: got %b want 0", i, a_cap_ready);
            end
        end
        rst = 1'b0;
        #1;
        tests++;
        if (a_cap_ready !== 1'b1) begin
            failed++;
            $display("FAIL idle_cap_ready: got %b want 1", a_cap_ready);
        end
        tests++;
        if (a_so_valid !== 1'b0 || a_so !== 1'b0 || a_so_last !== 1'b0) begin
            failed++;
            $display("FAIL idle_outputs: so_valid=%b so=%b so_last=%b want 0,0,0", a_so_valid, a_so, a_so_last);
        end
        tests++;
        if (a_frames !== 16'h0000) begin
            failed++;
            $display("FAIL reset_frames: got %h want 0000", a_frames);
        end
    endtask

    task automatic test_lsb_word;
        logic exp_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        do_reset();
        a_cap_data  = 8'hA5;
        a_cap_valid = 1'b1;
        a_so_ready  = 1'b1;
        tick();
        a_cap_valid = 1'b0;
        a_cap_data  = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (a_so_valid !== 1'b1 || a_so !== exp_bits[i] || a_so_last !== (i == 7)) begin
                failed++;
                $display("FAIL lsb_beat%0d: valid=%b so=%b last=%b want 1,%b,%b",
                         i, a_so_valid, a_so, a_so_last, exp_bits[i], (i == 7));
            end
            tick();
        end
        tests++;
        if (a_so_valid !== 1'b0 || a_cap_ready !== 1'b1) begin
            failed++;
            $display("FAIL lsb_back_to_idle: so_valid=%b cap_ready=%b want 0,1", a_so_valid, a_cap_ready);
        end
        tests++;
        if (a_frames !== 16'd1) begin
            failed++;
            $display("FAIL lsb_frames: got %0d want 1", a_frames);
        end
    endtask

    task automatic test_backpressure;
        logic exp_bits [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        int k = 0;
        int stall = 0;
        do_reset();
        b_cap_data  = 8'h81;
        b_cap_valid = 1'b1;
        b_so_ready  = 1'b1;
        tick();
        b_cap_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && k < 8; cyc++) begin
            if (k == 2 && stall < 3) begin
                b_so_ready = 1'b0;
                stall++;
                tests++;
                if (b_so_valid !== 1'b1 || b_so !== 1'b0 || b_so_last !== 1'b0) begin
                    failed++;
                    $display("FAIL bp_stall%0d: valid=%b so=%b last=%b want 1,0,0", stall, b_so_valid, b_so, b_so_last);
                end
            end else begin
                b_so_ready = 1'b1;
                tests++;
                if (b_so_valid !== 1'b1 || b_so !== exp_bits[k] || b_so_last !== (k == 7)) begin
                    failed++;
                    $display("FAIL bp_beat%0d: valid=%b so=%b last=%b want 1,%b,%b",
                             k, b_so_valid, b_so, b_so_last, exp_bits[k], (k == 7));
                end
                k++;
            end
            tick();
        end
        b_so_ready = 1'b0;
        tests++;
        if (k !== 8 || stall !== 3) begin
            failed++;
            $display("FAIL bp_beat_count: beats=%0d stalls=%0d want 8,3", k, stall);
        end
        tests++;
        if (b_so_valid !== 1'b0 || b_frames !== 16'd1) begin
            failed++;
            $display("FAIL bp_done: so_valid=%b frames=%0d want 0,1", b_so_valid, b_frames);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_bits [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        do_reset();
        a_cap_data  = 8'h0F;
        a_cap_valid = 1'b1;
        a_so_ready  = 1'b1;
        tick();
        a_cap_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (a_so_valid !== 1'b1 || a_so !== exp_bits[i] || a_so_last !== (i % 8 == 7)) begin
                failed++;
                $display("FAIL b2b_beat%0d: valid=%b so=%b last=%b want 1,%b,%b",
                         i, a_so_valid, a_so, a_so_last, exp_bits[i], (i % 8 == 7));
            end
            if (i < 8) begin
                tests++;
                if (a_cap_ready !== (i == 7)) begin
                    failed++;
                    $display("FAIL b2b_cap_ready%0d: got %b want %b", i, a_cap_ready, (i == 7));
                end
            end
            if (i == 8) begin
                a_cap_valid = 1'b0;
            end
            tick();
        end
        tests++;
        if (a_so_valid !== 1'b0 || a_frames !== 16'd2) begin
            failed++;
            $display("FAIL b2b_done: so_valid=%b frames=%0d want 0,2", a_so_valid, a_frames);
        end
    endtask

    task automatic test_midword_reset;
        int beats = 0;
        do_reset();
        a_cap_data  = 8'hFF;
        a_cap_valid = 1'b1;
        a_so_ready  = 1'b1;
        tick();
        a_cap_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (a_so_valid !== 1'b0 || a_so !== 1'b0 || a_cap_ready !== 1'b0) begin
            failed++;
            $display("FAIL midreset_async: so_valid=%b so=%b cap_ready=%b want 0,0,0", a_so_valid, a_so, a_cap_ready);
        end
        tests++;
        if (a_frames !== 16'd0) begin
            failed++;
            $display("FAIL midreset_frames: got %0d want 0", a_frames);
        end
        tick();
        rst = 1'b0;
        #1;
        a_cap_data  = 8'h01;
        a_cap_valid = 1'b1;
        tick();
        a_cap_valid = 1'b0;
        tests++;
        if (a_so_valid !== 1'b1 || a_so !== 1'b1 || a_so_last !== 1'b0) begin
            failed++;
            $display("FAIL midreset_restart: valid=%b so=%b last=%b want 1,1,0", a_so_valid, a_so, a_so_last);
        end
        for (int cyc = 0; cyc < 20 && a_so_valid === 1'b1; cyc++) begin
            beats++;
            tick();
        end
        tests++;
        if (beats !== 8 || a_frames !== 16'd1) begin
            failed++;
            $display("FAIL midreset_next_word: beats=%0d frames=%0d want 8,1", beats, a_frames);
        end
    endtask

    task automatic test_wrap_width1;
        int bad = 0;
        do_reset();
        c_cap_data  = 1'b1;
        c_cap_valid = 1'b1;
        c_so_ready  = 1'b1;
        tick();
        for (int i = 0; i < 65535; i++) begin
            if (c_so_valid !== 1'b1 || c_so_last !== 1'b1 || c_so !== 1'b1 || c_cap_ready !== 1'b1) begin
                bad++;
            end
            tick();
        end
        tests++;
        if (bad !== 0) begin
            failed++;
            $display("FAIL w1_each_frame: %0d bad cycles want 0", bad);
        end
        tests++;
        if (c_frames !== 16'hFFFF) begin
            failed++;
            $display("FAIL w1_preload: got %h want ffff", c_frames);
        end
        c_cap_valid = 1'b0;
        tests++;
        if (c_so_valid !== 1'b1 || c_so_last !== 1'b1) begin
            failed++;
            $display("FAIL w1_final_beat: valid=%b last=%b want 1,1", c_so_valid, c_so_last);
        end
        tick();
        tests++;
        if (c_frames !== 16'h0000 || c_so_valid !== 1'b0) begin
            failed++;
            $display("FAIL w1_wrap: frames=%h so_valid=%b want 0000,0", c_frames, c_so_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_lsb_word();
        test_backpressure();
        test_back_to_back();
        test_midword_reset();
        test_wrap_width1();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scan_chain_unloader.md
Name: scan_chain_unloader

Overview:
- Parallel-to-serial scan transmitter: captures a WIDTH-bit word from a parallel capture port and shifts it out one bit per accepted beat on a valid/ready serial port.
- It is the unload (transmit) end of the scan-chain interface whose load end deserializes a serial stream into parallel flip-flop state.
- Sits between a captured register bank (DFF Q outputs) and the test/oracle access port used to observe sequential netlists.

Parameters:
- WIDTH, 8, bits per captured word; legal range 1 to 1024.
- LSB_FIRST, 1, 1 shifts bit 0 first; 0 shifts bit WIDTH-1 first.
- CNT_W, max(1, clog2(WIDTH)), width of the beat counter; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cap_valid  input  1  capture word available.
- cap_ready  output  1  block can accept a capture this cycle.
- cap_data  input  WIDTH  word to serialize; sampled only on capture handshake.
- so  output  1  current serial bit.
- so_valid  output  1  so holds a valid bit.
- so_last  output  1  current bit is the final bit of the word.
- so_ready  input  1  downstream accepts the bit this cycle.
- frames_sent  output  16  count of fully transmitted words; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset, asynchronous while rst=1: state IDLE, shift register 0, cnt 0, frames_sent 0. so=0, so_valid=0, so_last=0. cap_ready=0 while rst is high. Reset mid-word discards the word with no partial frame count.
- States: IDLE and SHIFT.
- IDLE:
  - cap_ready=1, so_valid=0, so=0, so_last=0.
  - cap_valid=1 captures cap_data into the shift register and sets cnt=0; the next state is SHIFT.
  - Latency: the first bit appears on so the cycle after the capture handshake.
- SHIFT:
  - so_valid=1. so = shreg[0] when LSB_FIRST=1, else shreg[WIDTH-1].
  - so_last=1 iff cnt==WIDTH-1.
  - With so_ready=0, so, so_last and cnt are held stable; no bit is dropped or repeated.
  - With so_ready=1 and not last: shift by one toward the output end (zero fill), cnt+1.
  - With so_ready=1 and last: frames_sent+1 (mod 2^16).
    - If cap_valid=1 in the same cycle: capture the new word, cnt=0, stay in SHIFT (back-to-back, zero bubble).
    - Otherwise: go to IDLE.
- cap_ready = IDLE, or (SHIFT and so_last and so_ready). This is a combinational path from so_ready to cap_ready and is allowed.
- WIDTH=1: every SHIFT beat is last; the word still takes one cycle in SHIFT.
- cap_valid in SHIFT before the last beat is ignored; cap_ready=0 there.
- cap_data changes while not handshaking have no effect.
- Throughput: WIDTH beats per word at so_ready=1 continuously, with no idle cycles between back-to-back words.

Decomposition:
- Package scan_pkg:
  - state enum {IDLE, SHIFT};
  - cnt_width(WIDTH) function;
  - FRAME_CNT_W=16 constant, shared with the scan_chain_loader counterpart.
- One sub-module: scan_shreg. It is a WIDTH-bit load/shift register with a direction parameter, reused by the loader. The FSM, counter and frame counter stay in the top.

Test Plan:
- Reset/idle:
  - Stimulus: rst=1 for 3 cycles, then release.
  - Response: cap_ready=0 during reset; afterwards cap_ready=1, so_valid=0, frames_sent=0.
- LSB-first word, WIDTH=8, so_ready=1:
  - Stimulus: capture 0xA5.
  - Response: so sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after capture; so_last only on the 8th; frames_sent=1; returns to IDLE.
- Backpressure, LSB_FIRST=0:
  - Stimulus: capture 0x81; drop so_ready for 3 cycles after beat 2.
  - Response: so holds 0 for those 3 cycles; full sequence 1,0,0,0,0,0,0,1; 8 accepted beats total.
- Back-to-back:
  - Stimulus: 0x0F then 0xF0, with cap_valid held through the last beat.
  - Response: cap_ready=1 on beat 8; 16 contiguous so_valid beats; frames_sent=2.
- Mid-word reset:
  - Stimulus: assert rst after 4 beats of 0xFF.
  - Response: so_valid=0 immediately (async); frames_sent stays 0; the next capture starts at beat 0.
- Wrap and WIDTH=1:
  - Stimulus: preload frames_sent=0xFFFF via 65535 frames at WIDTH=1, then send one more.
  - Response: frames_sent=0x0000; each frame is exactly 1 SHIFT cycle with so_last=1.
